// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the left-turn traffic-light family.
//   - colour encoding driven onto La/Lb
//   - phase indices (A through, A left, B through, B left)
//   - scheduler control-state encoding
//   - helpers: phase one-hot and Moore light decode from (ctl, cur)
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  localparam logic [1:0] PH_AT = 2'd0;
  localparam logic [1:0] PH_AL = 2'd1;
  localparam logic [1:0] PH_BT = 2'd2;
  localparam logic [1:0] PH_BL = 2'd3;

  typedef enum logic [1:0] {
    GRN = 2'd0,
    YEL = 2'd1,
    ARD = 2'd2
  } ctl_t;

  function automatic logic [3:0] onehot4(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  // Returns {La, Lb} for a given control state and served phase.
  function automatic logic [3:0] decode_lights(input ctl_t c, input logic [1:0] cur);
    logic [3:0] l;
    l = {RED, RED};
    case (c)
      GRN: begin
        case (cur)
          PH_AT:   l = {GREEN, RED};
          PH_AL:   l = {LEFT, RED};
          PH_BT:   l = {RED, GREEN};
          default: l = {RED, LEFT};
        endcase
      end
      // cur[1] selects approach B (phases 2/3)
      YEL:     l = cur[1] ? {RED, YELLOW} : {YELLOW, RED};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// tl_rr_pick: combinational round-robin picker.
//   pend[3:0] : latched pending requests
//   cur[1:0]  : phase currently being left
//   nxt[1:0]  : first set pend bit in order cur+1, cur+2, cur+3 (mod 4)
//   any       : one of those three bits is set; nxt is only meaningful then
// The current phase itself is never a candidate.
module tl_rr_pick
  import tl_pkg::*;
(
  input  logic [3:0] pend,
  input  logic [1:0] cur,
  output logic [1:0] nxt,
  output logic       any
);

  logic [1:0] cand;

  // Scan farthest-first so the nearest set candidate is the last to win.
  always_comb begin
    nxt  = cur;
    any  = 1'b0;
    cand = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (pend[cand]) begin
        nxt = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_phase_sched.sv
// tl_phase_sched: timed four-phase intersection scheduler.
//   clk      : clock, all state changes on posedge
//   reset    : asynchronous, active-high
//   req[3:0] : car sensors (level) [0] A thru, [1] A left, [2] B thru, [3] B left
//   La, Lb   : approach A/B lights (GREEN 00, YELLOW 01, LEFT 10, RED 11)
//   phase    : phase currently served
//   pend     : latched pending requests
//   ctl_dbg  : control state (GRN/YEL/ARD) for observation
// Green lasts MIN_GREEN..MAX_GREEN cycles when another phase waits and
// indefinitely otherwise; yellow and all-red have fixed lengths. Pending
// phases are served round-robin; with nothing pending the home phase (A thru)
// is selected.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int TW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [1:0] phase,
  output logic [3:0] pend,
  output ctl_t       ctl_dbg
);

  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ARD_M1 = TW'(ALL_RED_T - 1);

  ctl_t          ctl, ctl_nxt;
  logic [1:0]    cur, cur_nxt;
  logic [TW-1:0] timer;
  logic [3:0]    clr, pend_nxt;
  logic          other;
  logic [1:0]    pick_nxt;
  logic          pick_any;

  tl_rr_pick u_pick (
    .pend (pend),
    .cur  (cur),
    .nxt  (pick_nxt),
    .any  (pick_any)
  );

  always_comb begin
    other   = |(pend & ~onehot4(cur));
    ctl_nxt = ctl;
    cur_nxt = cur;
    clr     = '0;
    case (ctl)
      GRN: begin
        // The served phase never latches its own request while green.
        clr = onehot4(cur);
        if (timer >= MIN_M1 && other && (!req[cur] || timer >= MAX_M1))
          ctl_nxt = YEL;
      end
      YEL: begin
        if (timer == YEL_M1)
          ctl_nxt = ARD;
      end
      ARD: begin
        if (timer == ARD_M1) begin
          ctl_nxt = GRN;
          cur_nxt = pick_any ? pick_nxt : PH_AT;
          clr     = onehot4(cur_nxt);
        end
      end
      default: ctl_nxt = GRN;
    endcase
    // Clear beats a simultaneous set.
    pend_nxt = (pend | req) & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl   <= GRN;
      cur   <= PH_AT;
      timer <= '0;
      pend  <= '0;
      La    <= GREEN;
      Lb    <= RED;
    end else begin
      ctl  <= ctl_nxt;
      cur  <= cur_nxt;
      pend <= pend_nxt;
      if (ctl_nxt != ctl)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + TW'(1);
      // Lights registered from the next state so they track (ctl, cur) exactly.
      {La, Lb} <= decode_lights(ctl_nxt, cur_nxt);
    end
  end

  assign phase   = cur;
  assign ctl_dbg = ctl;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Bench for tl_phase_sched. Outputs are observed as segments: a maximal run of
// cycles with constant {La, Lb, phase, pend}. Each expected segment (values and
// length in cycles) is queued by the stimulus code; the monitor closes a
// segment when the outputs change (or on a flush) and compares it with the
// head of the queue.
module tb_tl_phase_sched;
  import tl_pkg::*;

  localparam int W = 18;  // {la[2], lb[2], ph[2], pend[4], len[8]}

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] La, Lb, phase;
  logic [3:0] pend;
  ctl_t       ctl_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  logic       mon_en    = 1'b0;
  logic       flush_req = 1'b0;
  logic       seg_active = 1'b0;
  logic [1:0] s_la, s_lb, s_ph;
  logic [3:0] s_pend;
  int         s_len;

  tl_phase_sched #(
    .MIN_GREEN (4),
    .MAX_GREEN (10),
    .YELLOW_T  (3),
    .ALL_RED_T (2),
    .TW        (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .La      (La),
    .Lb      (Lb),
    .phase   (phase),
    .pend    (pend),
    .ctl_dbg (ctl_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [3:0] rv);
    reset = 1'b1;
    req   = 4'b0000;
    cyc(2);
    reset  = 1'b0;
    req    = rv;
    mon_en = 1'b1;
  endtask

  task automatic flush_mon();
    flush_req = 1'b1;
    @(negedge clk);
    #1;
    flush_req = 1'b0;
    mon_en    = 1'b0;
  endtask

  task automatic seg(input logic [1:0] la, input logic [1:0] lb, input logic [1:0] ph,
                     input logic [3:0] pd, input int len);
    exp_q.push_back({la, lb, ph, pd, 8'(len)});
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic close_seg();
    logic [W-1:0] e;
    logic [W-1:0] g;
    g = {s_la, s_lb, s_ph, s_pend, 8'(s_len)};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL segment: unexpected la=%0d lb=%0d ph=%0d pend=%b len=%0d",
               s_la, s_lb, s_ph, s_pend, s_len);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL segment: got la=%0d lb=%0d ph=%0d pend=%b len=%0d expected la=%0d lb=%0d ph=%0d pend=%b len=%0d",
                 s_la, s_lb, s_ph, s_pend, s_len,
                 e[17:16], e[15:14], e[13:12], e[11:8], e[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (flush_req) begin
      if (seg_active) close_seg();
      seg_active = 1'b0;
    end else if (mon_en) begin
      if (seg_active && {La, Lb, phase, pend} == {s_la, s_lb, s_ph, s_pend}) begin
        s_len++;
      end else begin
        if (seg_active) close_seg();
        s_la = La; s_lb = Lb; s_ph = phase; s_pend = pend;
        s_len = 1;
        seg_active = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    #1 reset = 1'b1;
    #2;
    check("reset_La", 8'(La), 8'(GREEN));
    check("reset_Lb", 8'(Lb), 8'(RED));
    check("reset_phase", 8'(phase), 8'(0));
    check("reset_pend", 8'(pend), 8'(0));
    check("reset_ctl", 8'(ctl_dbg), 8'(GRN));

    // 1: req[2] pulse right after release -> 4 green, 3 yellow, 2 all-red, B green
    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b0100, 3);
    seg(YELLOW, RED, 0, 4'b0100, 3);
    seg(RED, RED, 0, 4'b0100, 2);
    seg(RED, GREEN, 2, 4'b0000, 6);
    start_run(4'b0100);
    cyc(1); req = 4'b0000;
    cyc(14);
    flush_mon();

    // 2: idle for 50 cycles stays in home phase
    seg(GREEN, RED, 0, 4'b0000, 50);
    start_run(4'b0000);
    cyc(50);
    flush_mon();

    // 3: req[0] held, req[3] pulsed -> A green stretched to MAX_GREEN
    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b1000, 9);
    seg(YELLOW, RED, 0, 4'b1000, 3);
    seg(RED, RED, 0, 4'b1000, 2);
    seg(RED, LEFT, 3, 4'b0000, 5);
    start_run(4'b1001);
    cyc(1); req = 4'b0001;
    cyc(9); req = 4'b0000;
    cyc(10);
    flush_mon();

    // 4: all phases pending -> served 1, 2, 3, 0
    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b1110, 3);
    seg(YELLOW, RED, 0, 4'b1110, 3);
    seg(RED, RED, 0, 4'b1110, 2);
    seg(LEFT, RED, 1, 4'b1100, 1);
    seg(LEFT, RED, 1, 4'b1101, 3);
    seg(YELLOW, RED, 1, 4'b1101, 3);
    seg(RED, RED, 1, 4'b1101, 2);
    seg(RED, GREEN, 2, 4'b1001, 4);
    seg(RED, YELLOW, 2, 4'b1001, 3);
    seg(RED, RED, 2, 4'b1001, 2);
    seg(RED, LEFT, 3, 4'b0001, 4);
    seg(RED, YELLOW, 3, 4'b0001, 3);
    seg(RED, RED, 3, 4'b0001, 2);
    seg(GREEN, RED, 0, 4'b0000, 4);
    start_run(4'b1110);
    cyc(1); req = 4'b0000;
    cyc(8); req = 4'b0001;
    cyc(1); req = 4'b0000;
    cyc(30);
    flush_mon();

    // 5: req[1] during phase-1 yellow is held until phase 1 comes round again
    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b0010, 3);
    seg(YELLOW, RED, 0, 4'b0010, 3);
    seg(RED, RED, 0, 4'b0010, 2);
    seg(LEFT, RED, 1, 4'b0000, 1);
    seg(LEFT, RED, 1, 4'b0100, 3);
    seg(YELLOW, RED, 1, 4'b0100, 1);
    seg(YELLOW, RED, 1, 4'b0110, 2);
    seg(RED, RED, 1, 4'b0110, 2);
    seg(RED, GREEN, 2, 4'b0010, 4);
    seg(RED, YELLOW, 2, 4'b0010, 3);
    seg(RED, RED, 2, 4'b0010, 2);
    seg(LEFT, RED, 1, 4'b0000, 3);
    start_run(4'b0010);
    cyc(1); req = 4'b0000;
    cyc(8); req = 4'b0100;
    cyc(1); req = 4'b0000;
    cyc(3); req = 4'b0010;
    cyc(1); req = 4'b0000;
    cyc(16);
    flush_mon();

    // 6: reset during B yellow, then normal timing again
    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b0100, 3);
    seg(YELLOW, RED, 0, 4'b0100, 3);
    seg(RED, RED, 0, 4'b0100, 2);
    seg(RED, GREEN, 2, 4'b0000, 1);
    seg(RED, GREEN, 2, 4'b0001, 3);
    seg(RED, YELLOW, 2, 4'b0001, 1);
    start_run(4'b0100);
    cyc(1); req = 4'b0000;
    cyc(8); req = 4'b0001;
    cyc(1); req = 4'b0000;
    cyc(4);
    flush_mon();
    reset = 1'b1;
    #1;
    check("midreset_La", 8'(La), 8'(GREEN));
    check("midreset_Lb", 8'(Lb), 8'(RED));
    check("midreset_phase", 8'(phase), 8'(0));
    check("midreset_pend", 8'(pend), 8'(0));

    seg(GREEN, RED, 0, 4'b0000, 1);
    seg(GREEN, RED, 0, 4'b0100, 3);
    seg(YELLOW, RED, 0, 4'b0100, 3);
    seg(RED, RED, 0, 4'b0100, 2);
    seg(RED, GREEN, 2, 4'b0000, 6);
    start_run(4'b0100);
    cyc(1); req = 4'b0000;
    cyc(14);
    flush_mon();

    // Every queued segment must have been observed.
    check("leftover_expected", 8'(exp_q.size()), 8'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
